// File: rtl/pb_noc_link_pipe.sv
// Elastic pipeline for one inter-tile NoC link channel: a chain of 2-entry skid
// stages that registers valid, data and ready, plus saturating flit/stall counters.

module pb_noc_link_stage #(
    parameter int DataWidth = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data
);
    // Encoding chosen so out_valid and in_ready are single state flop bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t               state, state_next;
    logic [DataWidth-1:0] head, skid;
    logic                 push, pop;

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop) begin
                    state_next = FULL;
                end else if (pop && !push) begin
                    state_next = EMPTY;
                end
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = ~state[1];
        out_valid = state[0];
    end

    // head always shows the oldest flit; skid catches the one arriving during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else if (push) begin
            if (state == EMPTY || (state == ONE && pop)) begin
                head <= in_data;
            end else if (state == ONE) begin
                skid <= in_data;
            end
        end else if (pop && state == FULL) begin
            head <= skid;
        end
    end
endmodule

module pb_noc_link_pipe #(
    parameter int DataWidth = 64,
    parameter int NumStages = 1,
    parameter int CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic [CntWidth-1:0]  flit_cnt_o,
    output logic [CntWidth-1:0]  stall_cnt_o,
    output logic [(NumStages == 0 ? 1 : $clog2(2*NumStages+1))-1:0] occupancy_o
);
    localparam int OccWidth = (NumStages == 0) ? 1 : $clog2(2 * NumStages + 1);

    logic flit_evt, stall_evt;

    generate
        if (NumStages == 0) begin : g_pass
            assign out_valid_o = in_valid_i;
            assign out_data_o  = in_data_i;
            assign in_ready_o  = out_ready_i;
            assign occupancy_o = '0;
        end else begin : g_pipe
            logic [NumStages:0]   valid_chain;
            logic [NumStages:0]   ready_chain;
            logic [DataWidth-1:0] data_chain [NumStages+1];
            logic                 push, pop;
            logic [OccWidth-1:0]  occ;

            assign valid_chain[0]         = in_valid_i;
            assign data_chain[0]          = in_data_i;
            assign in_ready_o             = ready_chain[0];
            assign out_valid_o            = valid_chain[NumStages];
            assign out_data_o             = data_chain[NumStages];
            assign ready_chain[NumStages] = out_ready_i;

            for (genvar k = 0; k < NumStages; k++) begin : g_stage
                pb_noc_link_stage #(
                    .DataWidth(DataWidth)
                ) u_stage (
                    .clk      (clk_i),
                    .rst_n    (rst_ni),
                    .in_valid (valid_chain[k]),
                    .in_ready (ready_chain[k]),
                    .in_data  (data_chain[k]),
                    .out_valid(valid_chain[k+1]),
                    .out_ready(ready_chain[k+1]),
                    .out_data (data_chain[k+1])
                );
            end

            assign push = in_valid_i & in_ready_o;
            assign pop  = out_valid_o & out_ready_i;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    occ <= '0;
                end else if (push && !pop) begin
                    occ <= occ + OccWidth'(1);
                end else if (pop && !push) begin
                    occ <= occ - OccWidth'(1);
                end
            end

            assign occupancy_o = occ;
        end
    endgenerate

    assign flit_evt  = out_valid_o & out_ready_i;
    assign stall_evt = out_valid_o & ~out_ready_i;

    // Clear has priority over a same-cycle event; both counters stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flit_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else if (clr_i) begin
            flit_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (flit_evt && flit_cnt_o != '1) begin
                flit_cnt_o <= flit_cnt_o + CntWidth'(1);
            end
            if (stall_evt && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + CntWidth'(1);
            end
        end
    end
endmodule

// File: tb/tb_pb_noc_link_pipe.sv
// Scoreboard bench for pb_noc_link_pipe: four instances cover NumStages 2, 3, 1
// (4-bit counters) and 0 (passthrough).

module tb_pb_noc_link_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    logic        a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [31:0] a_flit_cnt, a_stall_cnt;
    logic [2:0]  a_occ;
    logic [63:0] a_q[$];

    logic        b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [15:0] b_flit_cnt, b_stall_cnt;
    logic [2:0]  b_occ;
    logic [63:0] b_q[$];

    logic        c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [63:0] c_in_data, c_out_data;
    logic [3:0]  c_flit_cnt, c_stall_cnt;
    logic [1:0]  c_occ;
    logic [63:0] c_q[$];

    logic        d_clr, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [63:0] d_in_data, d_out_data;
    logic [31:0] d_flit_cnt, d_stall_cnt;
    logic [0:0]  d_occ;

    pb_noc_link_pipe #(.DataWidth(64), .NumStages(2), .CntWidth(32)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .flit_cnt_o(a_flit_cnt), .stall_cnt_o(a_stall_cnt), .occupancy_o(a_occ)
    );

    pb_noc_link_pipe #(.DataWidth(64), .NumStages(3), .CntWidth(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .flit_cnt_o(b_flit_cnt), .stall_cnt_o(b_stall_cnt), .occupancy_o(b_occ)
    );

    pb_noc_link_pipe #(.DataWidth(64), .NumStages(1), .CntWidth(4)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(c_clr),
        .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_data_i(c_in_data),
        .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
        .flit_cnt_o(c_flit_cnt), .stall_cnt_o(c_stall_cnt), .occupancy_o(c_occ)
    );

    pb_noc_link_pipe #(.DataWidth(64), .NumStages(0), .CntWidth(32)) dut_d (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(d_clr),
        .in_valid_i(d_in_valid), .in_ready_o(d_in_ready), .in_data_i(d_in_data),
        .out_valid_o(d_out_valid), .out_ready_i(d_out_ready), .out_data_o(d_out_data),
        .flit_cnt_o(d_flit_cnt), .stall_cnt_o(d_stall_cnt), .occupancy_o(d_occ)
    );

    task automatic test_reset();
        rst_n = 1'b1;
        {a_clr, a_in_valid, a_out_ready, a_in_data} = '0;
        {b_clr, b_in_valid, b_out_ready, b_in_data} = '0;
        {c_clr, c_in_valid, c_out_ready, c_in_data} = '0;
        {d_clr, d_in_valid, d_out_ready, d_in_data} = '0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (a_out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b, required 0", a_out_valid); else passed++;
        total++; if (a_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b, required 1", a_in_ready); else passed++;
        total++; if (a_out_data !== 64'd0) $display("[TB] FAIL reset_out_data: got %0h, required 0", a_out_data); else passed++;
        total++; if (a_flit_cnt !== 32'd0 || a_stall_cnt !== 32'd0) $display("[TB] FAIL reset_counters: got %0d/%0d, required 0/0", a_flit_cnt, a_stall_cnt); else passed++;
        total++; if (a_occ !== 3'd0) $display("[TB] FAIL reset_occupancy: got %0d, required 0", a_occ); else passed++;
        total++; if (b_in_ready !== 1'b1 || c_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready_bc: got %0b%0b, required 11", b_in_ready, c_in_ready); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        int sent = 0, got = 0, cyc = 0, t_in = -1, t_out = -1, t_last = -1;
        logic [63:0] exp_data;
        a_out_ready = 1'b1;
        while (got < 100 && cyc < 400) begin
            @(negedge clk);
            a_in_valid = (sent < 100);
            a_in_data  = 64'(sent);
            #1;
            if (a_in_valid && a_in_ready) begin
                a_q.push_back(a_in_data);
                if (t_in < 0) t_in = cyc;
                sent++;
            end
            if (a_out_valid && a_out_ready) begin
                if (t_out < 0) t_out = cyc;
                t_last = cyc;
                total++;
                if (a_q.size() == 0) begin
                    $display("[TB] FAIL stream_data: got unexpected flit %0h, required none", a_out_data);
                end else begin
                    exp_data = a_q.pop_front();
                    if (a_out_data !== exp_data) $display("[TB] FAIL stream_data: got %0h, required %0h", a_out_data, exp_data); else passed++;
                end
                got++;
            end
            cyc++;
        end
        total++; if (got != 100) $display("[TB] FAIL stream_count: got %0d, required 100", got); else passed++;
        total++; if (t_out - t_in != 2) $display("[TB] FAIL stream_latency: got %0d, required 2", t_out - t_in); else passed++;
        total++; if (t_last - t_out != 99) $display("[TB] FAIL stream_throughput: got span %0d, required 99", t_last - t_out); else passed++;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        total++; if (a_flit_cnt !== 32'd100) $display("[TB] FAIL stream_flit_cnt: got %0d, required 100", a_flit_cnt); else passed++;
        total++; if (a_stall_cnt !== 32'd0) $display("[TB] FAIL stream_stall_cnt: got %0d, required 0", a_stall_cnt); else passed++;
        total++; if (a_occ !== 3'd0) $display("[TB] FAIL stream_occupancy: got %0d, required 0", a_occ); else passed++;
    endtask

    task automatic test_fill();
        int acc = 0, stall_exp = 0, pops = 0;
        bit pending = 1'b1, ready_back = 1'b0;
        logic [63:0] exp_data;
        a_out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_data  = 64'(1000 + acc);
            #1;
            total++; if (a_stall_cnt !== 32'(stall_exp)) $display("[TB] FAIL fill_stall_cnt: got %0d, required %0d", a_stall_cnt, stall_exp); else passed++;
            if (a_out_valid && !a_out_ready) stall_exp++;
            if (a_in_valid && a_in_ready) begin
                a_q.push_back(a_in_data);
                acc++;
            end
        end
        total++; if (acc != 4) $display("[TB] FAIL fill_accepts: got %0d, required 4", acc); else passed++;
        total++; if (a_in_ready !== 1'b0) $display("[TB] FAIL fill_in_ready: got %0b, required 0", a_in_ready); else passed++;
        total++; if (a_occ !== 3'd4) $display("[TB] FAIL fill_occupancy: got %0d, required 4", a_occ); else passed++;
        for (int c = 0; c < 30 && (pending || a_q.size() != 0); c++) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            a_in_valid  = pending;
            #1;
            if (a_in_ready) ready_back = 1'b1;
            if (a_in_valid && a_in_ready) begin
                a_q.push_back(a_in_data);
                pending = 1'b0;
            end
            if (a_out_valid && a_out_ready) begin
                pops++;
                total++;
                if (a_q.size() == 0) begin
                    $display("[TB] FAIL drain_data: got unexpected flit %0h, required none", a_out_data);
                end else begin
                    exp_data = a_q.pop_front();
                    if (a_out_data !== exp_data) $display("[TB] FAIL drain_data: got %0h, required %0h", a_out_data, exp_data); else passed++;
                end
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        total++; if (pops != 5 || a_q.size() != 0) $display("[TB] FAIL drain_count: got %0d pops %0d left, required 5 pops 0 left", pops, a_q.size()); else passed++;
        total++; if (!ready_back) $display("[TB] FAIL drain_in_ready: got 0, required 1"); else passed++;
        total++; if (a_occ !== 3'd0) $display("[TB] FAIL drain_occupancy: got %0d, required 0", a_occ); else passed++;
        total++; if (a_flit_cnt !== 32'd105) $display("[TB] FAIL drain_flit_cnt: got %0d, required 105", a_flit_cnt); else passed++;
        total++; if (a_stall_cnt !== 32'(stall_exp)) $display("[TB] FAIL drain_stall_cnt: got %0d, required %0d", a_stall_cnt, stall_exp); else passed++;
    endtask

    task automatic test_async_reset();
        int cyc = 0, t_in = -1, t_out = -1;
        a_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_data  = 64'(2000 + c);
            #1;
            if (a_in_valid && a_in_ready) a_q.push_back(a_in_data);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        total++; if (a_occ !== 3'd3 || a_out_valid !== 1'b1) $display("[TB] FAIL areset_held: got occ %0d valid %0b, required 3 1", a_occ, a_out_valid); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (a_out_valid !== 1'b0) $display("[TB] FAIL areset_out_valid: got %0b, required 0", a_out_valid); else passed++;
        total++; if (a_occ !== 3'd0) $display("[TB] FAIL areset_occupancy: got %0d, required 0", a_occ); else passed++;
        total++; if (a_flit_cnt !== 32'd0 || a_stall_cnt !== 32'd0) $display("[TB] FAIL areset_counters: got %0d/%0d, required 0/0", a_flit_cnt, a_stall_cnt); else passed++;
        total++; if (a_in_ready !== 1'b1) $display("[TB] FAIL areset_in_ready: got %0b, required 1", a_in_ready); else passed++;
        a_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        while (t_out < 0 && cyc < 12) begin
            @(negedge clk);
            a_in_valid = (t_in < 0);
            a_in_data  = 64'hABCD_0123;
            #1;
            if (a_in_valid && a_in_ready) t_in = cyc;
            if (a_out_valid && a_out_ready) begin
                t_out = cyc;
                total++; if (a_out_data !== 64'hABCD_0123) $display("[TB] FAIL areset_new_data: got %0h, required abcd0123", a_out_data); else passed++;
            end
            cyc++;
        end
        a_in_valid = 1'b0;
        total++; if (t_in < 0 || t_out - t_in != 2) $display("[TB] FAIL areset_latency: got %0d, required 2", t_out - t_in); else passed++;
    endtask

    task automatic test_random();
        int popped = 0, unstable = 0;
        bit pending = 1'b0, hold = 1'b0, done = 1'b0;
        logic [63:0] hold_data = '0;
        logic [63:0] exp_data;
        for (int cyc = 0; cyc < 10100 && !done; cyc++) begin
            @(negedge clk);
            if (cyc < 10000) begin
                if (!pending) begin
                    b_in_valid = 1'($urandom_range(0, 1));
                    b_in_data  = {$urandom, $urandom};
                end
                b_out_ready = 1'($urandom_range(0, 1));
            end else begin
                b_in_valid  = pending;
                b_out_ready = 1'b1;
            end
            #1;
            if (hold && (!b_out_valid || b_out_data !== hold_data)) unstable++;
            hold      = b_out_valid && !b_out_ready;
            hold_data = b_out_data;
            if (b_in_valid && b_in_ready) begin
                b_q.push_back(b_in_data);
                pending = 1'b0;
            end else begin
                pending = b_in_valid;
            end
            if (b_out_valid && b_out_ready) begin
                popped++;
                total++;
                if (b_q.size() == 0) begin
                    $display("[TB] FAIL random_data: got unexpected flit %0h, required none", b_out_data);
                end else begin
                    exp_data = b_q.pop_front();
                    if (b_out_data !== exp_data) $display("[TB] FAIL random_data: got %0h, required %0h", b_out_data, exp_data); else passed++;
                end
            end
            if (cyc >= 10000 && !pending && b_q.size() == 0 && !b_out_valid) done = 1'b1;
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        total++; if (!done || b_q.size() != 0) $display("[TB] FAIL random_loss: got %0d flits left, required 0", b_q.size()); else passed++;
        total++; if (unstable != 0) $display("[TB] FAIL random_stable: got %0d unstable cycles, required 0", unstable); else passed++;
        total++; if (b_flit_cnt !== 16'(popped)) $display("[TB] FAIL random_flit_cnt: got %0d, required %0d", b_flit_cnt, popped); else passed++;
        total++; if (b_occ !== 3'd0) $display("[TB] FAIL random_occupancy: got %0d, required 0", b_occ); else passed++;
    endtask

    task automatic test_saturation();
        int sent = 0, got = 0, model = 0;
        logic [63:0] exp_data;
        c_out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
            @(negedge clk);
            c_in_valid = (sent < 20);
            c_in_data  = 64'(sent);
            #1;
            total++; if (c_flit_cnt !== 4'((model > 15) ? 15 : model)) $display("[TB] FAIL sat_flit_cnt: got %0d, required %0d", c_flit_cnt, (model > 15) ? 15 : model); else passed++;
            if (c_in_valid && c_in_ready) begin
                c_q.push_back(c_in_data);
                sent++;
            end
            if (c_out_valid && c_out_ready) begin
                exp_data = (c_q.size() != 0) ? c_q.pop_front() : 64'hDEAD;
                total++; if (c_out_data !== exp_data) $display("[TB] FAIL sat_data: got %0h, required %0h", c_out_data, exp_data); else passed++;
                got++;
                model++;
            end
        end
        @(negedge clk);
        c_in_valid = 1'b0;
        #1;
        total++; if (c_flit_cnt !== 4'd15) $display("[TB] FAIL sat_hold: got %0d, required 15", c_flit_cnt); else passed++;
        @(negedge clk);
        c_in_valid = 1'b1;
        c_in_data  = 64'd99;
        @(negedge clk);
        c_in_valid = 1'b0;
        c_clr      = 1'b1;
        #1;
        total++; if (!(c_out_valid && c_out_ready)) $display("[TB] FAIL clr_handshake: got valid %0b, required 1", c_out_valid); else passed++;
        @(negedge clk);
        c_clr = 1'b0;
        #1;
        total++; if (c_flit_cnt !== 4'd0) $display("[TB] FAIL clr_flit_cnt: got %0d, required 0", c_flit_cnt); else passed++;
        @(negedge clk);
        #1;
        total++; if (c_flit_cnt !== 4'd0 || c_stall_cnt !== 4'd0) $display("[TB] FAIL clr_after: got %0d/%0d, required 0/0", c_flit_cnt, c_stall_cnt); else passed++;
    endtask

    task automatic test_passthrough();
        int flits = 0, stalls = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            d_in_valid  = 1'(i & 1);
            d_out_ready = 1'((i >> 1) & 1);
            d_in_data   = {$urandom, $urandom};
            #1;
            total++; if (d_out_valid !== d_in_valid || d_out_data !== d_in_data) $display("[TB] FAIL pass_forward: got %0b/%0h, required %0b/%0h", d_out_valid, d_out_data, d_in_valid, d_in_data); else passed++;
            total++; if (d_in_ready !== d_out_ready) $display("[TB] FAIL pass_ready: got %0b, required %0b", d_in_ready, d_out_ready); else passed++;
            total++; if (d_occ !== 1'b0) $display("[TB] FAIL pass_occupancy: got %0d, required 0", d_occ); else passed++;
            if (d_in_valid && d_out_ready) flits++;
            if (d_in_valid && !d_out_ready) stalls++;
        end
        @(negedge clk);
        d_in_valid = 1'b0;
        #1;
        total++; if (d_flit_cnt !== 32'(flits)) $display("[TB] FAIL pass_flit_cnt: got %0d, required %0d", d_flit_cnt, flits); else passed++;
        total++; if (d_stall_cnt !== 32'(stalls)) $display("[TB] FAIL pass_stall_cnt: got %0d, required %0d", d_stall_cnt, stalls); else passed++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill();
        test_async_reset();
        test_random();
        test_saturation();
        test_passthrough();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
